// File: rtl/spi_cmd_sequencer.sv
// Command path between SPI_Slave and the lab fsm: buffers RX bytes in a FIFO,
// decodes them one at a time, strobes the fsm step, and loads TX replies.
module spi_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [7:0]  CMD_READ_STATE = 8'hFF,
  parameter logic [7:0]  CMD_READ_STAT  = 8'hFE
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic [7:0] i_State,
  output logic       o_FSM_Signal,
  output logic       o_FSM_Step,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_Busy,
  output logic [3:0] o_Err_Cnt,
  output logic [3:0] o_Ovf_Cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SETTLE,
    S_LOAD_TX
  } state_t;

  state_t r_State, w_Next;

  logic [7:0]    r_Mem [FIFO_DEPTH];
  logic [AW-1:0] r_Wr_Ptr, r_Rd_Ptr;
  logic [AW:0]   r_Count;
  logic [7:0]    r_Cmd;
  logic [CW-1:0] r_Cnt;
  logic          r_FSM_Signal, r_FSM_Step, r_TX_DV;
  logic [7:0]    r_TX_Byte;
  logic [3:0]    r_Err_Cnt, r_Ovf_Cnt;

  logic w_Empty, w_Full, w_Pop, w_Push, w_Ovf;
  logic w_Is_Feed, w_Is_Read, w_Step, w_Tx, w_Err_Inc, w_Stat_Clr;

  assign w_Empty   = (r_Count == '0);
  assign w_Full    = (r_Count == DEPTH_C);
  assign w_Pop     = (r_State == S_IDLE) && !w_Empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_Push    = i_RX_DV && (!w_Full || w_Pop);
  assign w_Ovf     = i_RX_DV && w_Full && !w_Pop;
  assign w_Is_Feed = (r_Cmd[7:1] == 7'd0);
  assign w_Is_Read = (r_Cmd == CMD_READ_STATE) || (r_Cmd == CMD_READ_STAT);
  assign w_Stat_Clr = w_Tx && (r_Cmd == CMD_READ_STAT);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next    = r_State;
    w_Step    = 1'b0;
    w_Tx      = 1'b0;
    w_Err_Inc = 1'b0;
    case (r_State)
      S_IDLE: begin
        if (!w_Empty) w_Next = S_DECODE;
      end
      S_DECODE: begin
        if (w_Is_Feed) begin
          w_Step = 1'b1;
          w_Next = S_SETTLE;
        end else if (w_Is_Read) begin
          w_Next = S_LOAD_TX;
        end else begin
          w_Err_Inc = 1'b1;
          w_Next    = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (r_Cnt == CW'(1)) w_Next = S_IDLE;
      end
      S_LOAD_TX: begin
        w_Tx   = 1'b1;
        w_Next = S_IDLE;
      end
      default: w_Next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Wr_Ptr     <= '0;
      r_Rd_Ptr     <= '0;
      r_Count      <= '0;
      r_Cmd        <= '0;
      r_Cnt        <= '0;
      r_FSM_Signal <= 1'b0;
      r_FSM_Step   <= 1'b0;
      r_TX_DV      <= 1'b0;
      r_TX_Byte    <= '0;
      r_Err_Cnt    <= '0;
      r_Ovf_Cnt    <= '0;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Pop) begin
        r_Cmd    <= r_Mem[r_Rd_Ptr];
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase

      r_FSM_Step <= w_Step;
      r_TX_DV    <= w_Tx;
      if (w_Step) r_FSM_Signal <= r_Cmd[0];

      if (w_Step)                  r_Cnt <= SETTLE_C;
      else if (r_State == S_SETTLE) r_Cnt <= r_Cnt - 1'b1;

      if (w_Tx) begin
        if (r_Cmd == CMD_READ_STAT) r_TX_Byte <= {r_Ovf_Cnt, r_Err_Cnt};
        else                        r_TX_Byte <= i_State;
      end

      if (w_Stat_Clr)                          r_Err_Cnt <= '0;
      else if (w_Err_Inc && r_Err_Cnt != '1)   r_Err_Cnt <= r_Err_Cnt + 4'd1;

      // Clearing read wins, but a drop in the same cycle is still counted.
      if (w_Stat_Clr)                          r_Ovf_Cnt <= {3'b000, w_Ovf};
      else if (w_Ovf && r_Ovf_Cnt != '1)       r_Ovf_Cnt <= r_Ovf_Cnt + 4'd1;
    end
  end

  assign o_FSM_Signal = r_FSM_Signal;
  assign o_FSM_Step   = r_FSM_Step;
  assign o_TX_DV      = r_TX_DV;
  assign o_TX_Byte    = r_TX_Byte;
  assign o_Busy       = (r_State != S_IDLE) || !w_Empty;
  assign o_Err_Cnt    = r_Err_Cnt;
  assign o_Ovf_Cnt    = r_Ovf_Cnt;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: an edge-scheduled command model
// predicts strobes and counters; a negedge monitor compares every cycle.
module tb_spi_cmd_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] state_in = 8'h00;
  logic       o_FSM_Signal, o_FSM_Step, o_TX_DV, o_Busy;
  logic [7:0] o_TX_Byte;
  logic [3:0] o_Err_Cnt, o_Ovf_Cnt;

  spi_cmd_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .CMD_READ_STATE(8'hFF),
    .CMD_READ_STAT (8'hFE)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_State     (state_in),
    .o_FSM_Signal(o_FSM_Signal),
    .o_FSM_Step  (o_FSM_Step),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .o_Busy      (o_Busy),
    .o_Err_Cnt   (o_Err_Cnt),
    .o_Ovf_Cnt   (o_Ovf_Cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    bit         is_tx;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] m_fifo[$];
  int         edge_cnt = 0;
  int         free_edge = 0;
  int         dec_edge = 0;
  int         tx_edge = 0;
  bit         pend_dec = 1'b0;
  bit         pend_tx = 1'b0;
  bit         tx_stat = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  logic [3:0] m_err = 4'h0;
  logic [3:0] m_ovf = 4'h0;
  logic       m_sig = 1'b0;
  logic [7:0] m_tx = 8'h00;
  bit         m_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_steps = 0;
  int n_tx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // Reference model: a command popped at edge e is decoded at e+1, a read
  // loads TX at e+2, and the engine accepts the next pop after its duration.
  initial forever begin
    logic [7:0] b;
    bit         pop;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      pend_dec = 1'b0;
      pend_tx = 1'b0;
      free_edge = 0;
      m_err = 4'h0;
      m_ovf = 4'h0;
      m_sig = 1'b0;
      m_tx = 8'h00;
    end else begin
      if (pend_tx && edge_cnt == tx_edge) begin
        b = tx_stat ? {m_ovf, m_err} : state_in;
        m_tx = b;
        exp_q.push_back('{edge_cnt, 1'b1, b});
        if (tx_stat) begin
          m_ovf = 4'h0;
          m_err = 4'h0;
        end
        pend_tx = 1'b0;
      end
      if (pend_dec && edge_cnt == dec_edge) begin
        pend_dec = 1'b0;
        if (m_cmd == 8'h00 || m_cmd == 8'h01) begin
          m_sig = m_cmd[0];
          exp_q.push_back('{edge_cnt, 1'b0, {7'd0, m_cmd[0]}});
        end else if (m_cmd == 8'hFF || m_cmd == 8'hFE) begin
          pend_tx = 1'b1;
          tx_edge = edge_cnt + 1;
          tx_stat = (m_cmd == 8'hFE);
        end else if (m_err != 4'hF) begin
          m_err = m_err + 4'd1;
        end
      end
      pop = (edge_cnt >= free_edge) && (m_fifo.size() != 0);
      if (pop) begin
        m_cmd = m_fifo.pop_front();
        pend_dec = 1'b1;
        dec_edge = edge_cnt + 1;
        if (m_cmd == 8'h00 || m_cmd == 8'h01) free_edge = edge_cnt + 2 + int'(SETTLE);
        else if (m_cmd == 8'hFF || m_cmd == 8'hFE) free_edge = edge_cnt + 3;
        else free_edge = edge_cnt + 2;
      end
      if (rx_dv) begin
        if (m_fifo.size() < int'(DEPTH)) m_fifo.push_back(rx_byte);
        else if (m_ovf != 4'hF) m_ovf = m_ovf + 4'd1;
      end
    end
    m_busy = (m_fifo.size() != 0) || (edge_cnt < free_edge - 1);
  end

  initial forever begin
    ev_t ev;
    @(negedge clk);
    check("busy", 32'(o_Busy), 32'(m_busy));
    check("err_cnt", 32'(o_Err_Cnt), 32'(m_err));
    check("ovf_cnt", 32'(o_Ovf_Cnt), 32'(m_ovf));
    check("fsm_signal", 32'(o_FSM_Signal), 32'(m_sig));
    check("tx_byte_held", 32'(o_TX_Byte), 32'(m_tx));
    if (o_FSM_Step || o_TX_DV) begin
      if (o_FSM_Step) n_steps++;
      if (o_TX_DV) n_tx++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'({o_FSM_Step, o_TX_DV}), 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("strobe_edge", 32'(edge_cnt), 32'(ev.edge_no));
        check("strobe_kind", 32'({o_FSM_Step, o_TX_DV}), ev.is_tx ? 32'd1 : 32'd2);
        check("strobe_val", ev.is_tx ? 32'(o_TX_Byte) : 32'(o_FSM_Signal), 32'(ev.val));
      end
    end else if (exp_q.size() != 0) begin
      check("strobe_due", 32'(exp_q[0].edge_no > edge_cnt), 32'd1);
      if (exp_q[0].edge_no <= edge_cnt) void'(exp_q.pop_front());
    end
  end

  task automatic tick(input bit dv, input logic [7:0] b);
    rx_dv = dv;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_Busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 200), 32'd1);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t0, r, sel;
    logic [7:0] b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Reset mid-SETTLE with two bytes still queued
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h00);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    s0 = n_steps;
    t0 = n_tx;
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_signal", 32'(o_FSM_Signal), 32'd0);
    check("rst_txbyte", 32'(o_TX_Byte), 32'd0);
    idle(10);
    check("rst_no_step", 32'(n_steps - s0), 32'd0);
    check("rst_no_tx", 32'(n_tx - t0), 32'd0);

    // Feed then read state
    state_in = 8'h05;
    s0 = n_steps;
    tick(1'b1, 8'h01);
    tick(1'b1, 8'hFF);
    wait_idle();
    check("feed_signal", 32'(o_FSM_Signal), 32'd1);
    check("read_state_byte", 32'(o_TX_Byte), 32'h05);
    check("feed_one_step", 32'(n_steps - s0), 32'd1);

    // Burst while busy
    s0 = n_steps;
    tick(1'b1, 8'h01);
    idle($urandom_range(0, 2));
    repeat (6) tick(1'b1, 8'h00);
    wait_idle();
    check("burst_steps", 32'(n_steps - s0), 32'(7 - int'(m_ovf)));

    // Error counter saturation, then status read
    tick(1'b1, 8'hFE);
    wait_idle();
    s0 = n_steps;
    t0 = n_tx;
    repeat (17) begin
      tick(1'b1, 8'h42);
      tick(1'b0, 8'h00);
    end
    wait_idle();
    check("err_sat", 32'(o_Err_Cnt), 32'hF);
    check("err_no_step", 32'(n_steps - s0), 32'd0);
    check("err_no_tx", 32'(n_tx - t0), 32'd0);
    tick(1'b1, 8'hFE);
    wait_idle();
    check("stat_byte", 32'(o_TX_Byte), 32'h0F);
    check("stat_err_clr", 32'(o_Err_Cnt), 32'd0);
    check("stat_ovf_clr", 32'(o_Ovf_Cnt), 32'd0);

    // Overflow in the same cycle as the status load
    tick(1'b1, 8'h01);
    tick(1'b1, 8'hFE);
    repeat (6) tick(1'b1, 8'h00);
    wait_idle();
    check("stat_ovf_byte", 32'(o_TX_Byte), 32'h10);
    check("stat_ovf_after", 32'(o_Ovf_Cnt), 32'd1);

    // Full FIFO with simultaneous push and pop
    s0 = n_steps;
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h00);
    wait_idle();
    check("full_pushpop_steps", 32'(n_steps - s0), 32'd6);
    check("full_pushpop_ovf", 32'(o_Ovf_Cnt), 32'd1);
    check("full_pushpop_last", 32'(o_FSM_Signal), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      state_in = 8'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      r = $urandom_range(0, 9);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2: b = 8'h00;
        3, 4:    b = 8'h01;
        5:       b = 8'hFF;
        6:       b = 8'hFE;
        default: b = 8'($urandom);
      endcase
      tick(r < 5, b);
    end
    rst = 1'b0;
    wait_idle();
    check("no_pending_strobes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
